// File: rtl/mops_sdo_responder.sv
// MOPS-side CANopen SDO responder for one emulated bus: answers ADC upload
// requests from the hub, emits abort frames on bad requests, and sends the bootup frame.
module mops_sdo_responder #(
  parameter logic [6:0] NODE_ID     = 7'h00,
  parameter logic [7:0] N_ADC       = 8'd35,
  parameter logic [7:0] RESP_DELAY  = 8'd8,
  parameter logic [7:0] ADC_TIMEOUT = 8'd255
) (
  input  logic        clk_40_m,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [75:0] req_frame,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [75:0] rsp_frame,
  input  logic        sign_on,
  output logic        adc_rd_en,
  output logic [7:0]  adc_ch,
  input  logic [15:0] adc_value,
  input  logic        adc_valid,
  output logic        busy,
  output logic [15:0] req_cnt,
  output logic [7:0]  abort_cnt
);

  localparam logic [10:0] ID_RX   = 11'h600 + {4'd0, NODE_ID};
  localparam logic [10:0] ID_TX   = 11'h580 + {4'd0, NODE_ID};
  localparam logic [10:0] ID_BOOT = 11'h700 + {4'd0, NODE_ID};

  localparam logic [31:0] AB_CMD     = 32'h0504_0001;
  localparam logic [31:0] AB_NOOBJ   = 32'h0602_0000;
  localparam logic [31:0] AB_TIMEOUT = 32'h0800_0000;

  typedef enum logic [2:0] {IDLE, DECODE, ADC_REQ, ADC_WAIT, DELAY, SEND} state_t;

  state_t      state;
  logic [31:0] req_hdr;     // bytes0..3 of the accepted request
  logic        boot_pend;
  logic        sign_on_q;
  logic [7:0]  wait_cnt;
  logic [7:0]  dly_cnt;

  logic        build;
  logic        is_abort;
  logic [31:0] ab_code;
  logic [75:0] build_frame;

  wire       sign_rise = sign_on & ~sign_on_q;
  wire [7:0] cmd       = req_hdr[31:24];
  wire [15:0] index    = {req_hdr[15:8], req_hdr[23:16]};
  wire [7:0] sub       = req_hdr[7:0];

  // RTR bit and bytes4..7 of a request carry nothing for an upload initiate
  wire unused_req_bits = ^{req_frame[64], req_frame[31:0]};

  assign req_ready = rst && (state == IDLE) && !boot_pend;
  assign busy      = (state != IDLE);

  // Frame to launch this cycle, if any; aborts share one layout
  always_comb begin
    build       = 1'b0;
    is_abort    = 1'b0;
    ab_code     = 32'h0;
    build_frame = 76'h0;
    case (state)
      IDLE:
        if (boot_pend) begin
          build       = 1'b1;
          build_frame = {ID_BOOT, 1'b0, 64'h0};
        end
      DECODE:
        if (cmd != 8'h40) begin
          build = 1'b1; is_abort = 1'b1; ab_code = AB_CMD;
        end else if (index != 16'h2400 || sub == 8'h00 || sub > N_ADC) begin
          build = 1'b1; is_abort = 1'b1; ab_code = AB_NOOBJ;
        end
      ADC_WAIT:
        if (adc_valid) begin
          build       = 1'b1;
          build_frame = {ID_TX, 1'b0, 8'h43, req_hdr[23:0],
                         adc_value[7:0], adc_value[15:8], 16'h0};
        end else if ({1'b0, wait_cnt} + 9'd1 >= {1'b0, ADC_TIMEOUT}) begin
          build = 1'b1; is_abort = 1'b1; ab_code = AB_TIMEOUT;
        end
      default: ;
    endcase
    if (is_abort)
      build_frame = {ID_TX, 1'b0, 8'h80, req_hdr[23:0],
                     ab_code[7:0], ab_code[15:8], ab_code[23:16], ab_code[31:24]};
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state     <= IDLE;
      req_hdr   <= 32'h0;
      boot_pend <= 1'b0;
      sign_on_q <= 1'b0;
      wait_cnt  <= 8'h0;
      dly_cnt   <= 8'h0;
      rsp_valid <= 1'b0;
      rsp_frame <= 76'h0;
      adc_rd_en <= 1'b0;
      adc_ch    <= 8'h0;
      req_cnt   <= 16'h0;
      abort_cnt <= 8'h0;
    end else begin
      sign_on_q <= sign_on;
      adc_rd_en <= 1'b0;
      case (state)
        IDLE:
          if (boot_pend)
            boot_pend <= 1'b0;
          else if (req_valid && req_frame[75:65] == ID_RX) begin
            req_hdr <= req_frame[63:32];
            req_cnt <= req_cnt + 16'd1;
            state   <= DECODE;
          end
        DECODE:
          if (!build) begin
            adc_rd_en <= 1'b1;
            adc_ch    <= sub;
            state     <= ADC_REQ;
          end
        ADC_REQ: begin
          wait_cnt <= 8'h0;
          state    <= ADC_WAIT;
        end
        ADC_WAIT:
          if (!build) wait_cnt <= wait_cnt + 8'd1;
        DELAY:
          if ({1'b0, dly_cnt} + 9'd1 >= {1'b0, RESP_DELAY}) begin
            rsp_valid <= 1'b1;
            state     <= SEND;
          end else
            dly_cnt <= dly_cnt + 8'd1;
        SEND:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            adc_ch    <= 8'h0;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase

      if (build) begin
        rsp_frame <= build_frame;
        if (is_abort && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
        if (RESP_DELAY == 8'd0) begin
          rsp_valid <= 1'b1;
          state     <= SEND;
        end else begin
          dly_cnt <= 8'h0;
          state   <= DELAY;
        end
      end

      // A new edge wins over the clear so it is never lost
      if (sign_rise) boot_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mops_sdo_responder.sv
// Scoreboard bench for mops_sdo_responder: expected frames queued at stimulus,
// compared at each rsp handshake.
module tb_mops_sdo_responder;

  logic        clk_40_m;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [75:0] req_frame;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [75:0] rsp_frame;
  logic        sign_on;
  logic        adc_rd_en;
  logic [7:0]  adc_ch;
  logic [15:0] adc_value;
  logic        adc_valid;
  logic        busy;
  logic [15:0] req_cnt;
  logic [7:0]  abort_cnt;

  mops_sdo_responder #(
    .NODE_ID(7'h00), .N_ADC(8'd35), .RESP_DELAY(8'd0), .ADC_TIMEOUT(8'd255)
  ) dut (
    .clk_40_m(clk_40_m), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_frame(req_frame),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_frame(rsp_frame),
    .sign_on(sign_on),
    .adc_rd_en(adc_rd_en), .adc_ch(adc_ch), .adc_value(adc_value), .adc_valid(adc_valid),
    .busy(busy), .req_cnt(req_cnt), .abort_cnt(abort_cnt)
  );

  initial begin
    clk_40_m = 1'b0;
    forever #5 clk_40_m = ~clk_40_m;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rd  = 0;
  logic [75:0] exp_q[$];

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [75:0] frm(input logic [10:0] id, input logic [63:0] d);
    return {id, 1'b0, d};
  endfunction

  task automatic tick();
    @(posedge clk_40_m);
    #1;
  endtask

  // Handshake lands on the next edge; returns in the DECODE cycle
  task automatic send_req(input logic [10:0] id, input logic [63:0] d);
    for (int i = 0; i < 50; i++) begin
      if (req_ready) break;
      tick();
    end
    if (!req_ready) chk("req_ready_timeout", 76'(req_ready), 76'(1));
    req_valid = 1'b1;
    req_frame = frm(id, d);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rd();
    for (int i = 0; i < 10; i++) begin
      if (adc_rd_en) break;
      tick();
    end
    if (!adc_rd_en) chk("rd_en_timeout", 76'(adc_rd_en), 76'(1));
  endtask

  task automatic drain(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    if (exp_q.size() != 0 || busy) chk(tag, 76'(exp_q.size()), 76'(0));
  endtask

  task automatic run_normal(input logic [7:0] sub, input logic [15:0] val);
    exp_q.push_back(frm(11'h580, {8'h43, 8'h00, 8'h24, sub, val[7:0], val[15:8], 16'h0}));
    send_req(11'h600, {8'h40, 8'h00, 8'h24, sub, 32'h0});
    wait_rd();
    chk("adc_ch", 76'(adc_ch), 76'(sub));
    tick();
    adc_value = val;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    drain("normal_drain", 20);
  endtask

  // Count response handshakes and read strobes half a cycle before the edge
  always @(negedge clk_40_m) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("spurious_rsp", rsp_frame, 76'(0));
      else chk("rsp_frame", rsp_frame, exp_q.pop_front());
    end
    if (adc_rd_en) n_rd++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [75:0] expn;
  logic        bad;
  int          rd0;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_frame = '0; rsp_ready = 1'b1;
    sign_on = 1'b0; adc_value = '0; adc_valid = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", 76'(req_ready), 76'(0));
    chk("rst_rsp_valid", 76'(rsp_valid), 76'(0));
    chk("rst_rsp_frame", rsp_frame, 76'(0));
    chk("rst_req_cnt", 76'(req_cnt), 76'(0));
    chk("rst_abort_cnt", 76'(abort_cnt), 76'(0));
    chk("rst_busy", 76'({busy, adc_rd_en, adc_ch}), 76'(0));
    rst = 1'b1;
    tick();
    chk("idle_req_ready", 76'(req_ready), 76'(1));

    // Normal upload with exact latency checks
    exp_q.push_back(frm(11'h580, 64'h4300_2405_2B1A_0000));
    send_req(11'h600, 64'h4000_2405_0000_0000);
    chk("decode_busy", 76'(busy), 76'(1));
    tick();
    chk("rd_en_latency", 76'(adc_rd_en), 76'(1));
    chk("adc_ch5", 76'(adc_ch), 76'(5));
    tick();
    chk("rd_en_one_cycle", 76'(adc_rd_en), 76'(0));
    tick();
    adc_value = 16'h1A2B;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    chk("rsp_latency", 76'(rsp_valid), 76'(1));
    tick();
    chk("rsp_one_pulse", 76'(rsp_valid), 76'(0));
    chk("req_ready_back", 76'(req_ready), 76'(1));
    chk("req_cnt_1", 76'(req_cnt), 76'(1));
    chk("q_after_first", 76'(exp_q.size()), 76'(0));

    // Subindex beyond N_ADC: abort, no ADC read
    rd0 = n_rd;
    exp_q.push_back(frm(11'h580, 64'h8000_2424_0000_0206));
    send_req(11'h600, 64'h4000_2424_0000_0000);
    drain("sub_hi_drain", 20);
    chk("abort_cnt_1", 76'(abort_cnt), 76'(1));
    chk("no_rd_en_on_abort", 76'(n_rd), 76'(rd0));

    // Boundaries: last valid subindex, subindex 0, wrong index, wrong command
    run_normal(8'd35, 16'hBEEF);
    exp_q.push_back(frm(11'h580, 64'h8000_2400_0000_0206));
    send_req(11'h600, 64'h4000_2400_0000_0000);
    drain("sub0_drain", 20);
    exp_q.push_back(frm(11'h580, 64'h8001_2405_0000_0206));
    send_req(11'h600, 64'h4001_2405_0000_0000);
    drain("index_drain", 20);
    exp_q.push_back(frm(11'h580, 64'h8000_2405_0100_0405));
    send_req(11'h600, 64'h2300_2405_0000_0000);
    drain("cmd_drain", 20);
    chk("abort_cnt_4", 76'(abort_cnt), 76'(4));

    // Foreign node id: dropped silently
    send_req(11'h601, 64'h4000_2405_0000_0000);
    repeat (10) tick();
    chk("req_cnt_drop", 76'(req_cnt), 76'(6));
    chk("busy_drop", 76'(busy), 76'(0));

    // ADC never answers; a strobe during ADC_REQ must be ignored
    exp_q.push_back(frm(11'h580, 64'h8000_2407_0000_0008));
    send_req(11'h600, 64'h4000_2407_0000_0000);
    tick();
    adc_value = 16'hDEAD;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    repeat (100) tick();
    chk("no_early_timeout", 76'(rsp_valid), 76'(0));
    drain("timeout_drain", 400);
    chk("abort_cnt_5", 76'(abort_cnt), 76'(5));

    // Bootup requested mid-transaction, two edges merge; response held 20 cycles
    expn = frm(11'h580, 64'h4300_2403_4433_0000);
    exp_q.push_back(expn);
    exp_q.push_back(frm(11'h700, 64'h0));
    send_req(11'h600, 64'h4000_2403_0000_0000);
    tick();
    tick();
    sign_on = 1'b1;
    tick();
    sign_on = 1'b0;
    tick();
    sign_on = 1'b1;
    rsp_ready = 1'b0;
    adc_value = 16'h3344;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      if (rsp_valid !== 1'b1 || rsp_frame !== expn || req_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("hold_stable", 76'(bad), 76'(0));
    rsp_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      if (req_ready) bad = 1'b1;
      tick();
    end
    chk("boot_req_ready_low", 76'(bad), 76'(0));
    chk("boot_drain", 76'(exp_q.size()), 76'(0));
    chk("ready_after_boot", 76'(req_ready), 76'(1));
    chk("abort_cnt_boot", 76'(abort_cnt), 76'(5));
    sign_on = 1'b0;
    repeat (3) tick();

    // Reset while SEND is stalled drops the response
    rsp_ready = 1'b0;
    send_req(11'h600, 64'h4000_2401_0000_0000);
    wait_rd();
    tick();
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    chk("send_before_rst", 76'(rsp_valid), 76'(1));
    rst = 1'b0;
    tick();
    chk("rst_send_valid", 76'(rsp_valid), 76'(0));
    chk("rst_send_busy", 76'(busy), 76'(0));
    chk("rst_send_cnts", 76'({req_cnt, abort_cnt}), 76'(0));
    chk("rst_send_frame", rsp_frame, 76'(0));
    rst = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_ready", 76'(req_ready), 76'(1));
    chk("q_final", 76'(exp_q.size()), 76'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mops_sdo_responder.md
# mops_sdo_responder

Behavioural responder for one CAN bus of the MOPSHUB bench: it plays the MOPS end of the CANopen SDO exchange the hub initiates. It accepts decoded 76-bit request frames from the bus decoder, fetches the requested ADC channel value from the bus emulator, and hands a 76-bit response or abort frame to the bus transmitter. It also emits the bootup (sign-on) frame. One instance per bus sits between the CAN decoder and encoder inside the data generator.

## Interface
- NODE_ID, 7'h00: CANopen node id of the emulated MOPS.
- N_ADC, 8'd35: number of valid ADC subindices (1..N_ADC).
- RESP_DELAY, 8'd8: extra cycles inserted before every response; 0 means no delay.
- ADC_TIMEOUT, 8'd255: cycles to wait for adc_valid before aborting.
- Frame format, all 76-bit frames: [75:65] COB-ID, [64] RTR (0 on transmit, ignored on receive), [63:0] data, byte0 = [63:56] … byte7 = [7:0].

Ports:
- clk_40_m  in  1  bench clock, 40 MHz.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request frame present.
- req_ready  out  1  responder can accept a request.
- req_frame  in  76  request frame.
- rsp_valid  out  1  response frame present.
- rsp_ready  in  1  transmitter takes the response.
- rsp_frame  out  76  response frame.
- sign_on  in  1  request to send the bootup frame; rising edge is the event.
- adc_rd_en  out  1  one-cycle ADC read strobe.
- adc_ch  out  8  ADC channel being read, equal to the request subindex.
- adc_value  in  16  ADC result.
- adc_valid  in  1  adc_value valid this cycle.
- busy  out  1  state is not IDLE.
- req_cnt  out  16  accepted requests addressed to NODE_ID.
- abort_cnt  out  8  abort responses sent.

## Operation
- States: IDLE, DECODE, ADC_REQ, ADC_WAIT, DELAY, SEND.
- req_ready = 1 only in IDLE with no bootup pending; it is forced to 0 while rst = 0.
- IDLE:
  - If a bootup is pending, build frame ID 0x700+NODE_ID with byte0 = 0x00 and all other bytes 0, then go to DELAY. Bootup has priority over requests.
  - Otherwise, on req_valid && req_ready, latch req_frame. If COB-ID = 0x600+NODE_ID, increment req_cnt and go to DECODE. If the ID does not match, drop the frame: no response and no count change.
- DECODE, classified in this order:
  - byte0 ≠ 0x40: abort with code 0x05040001.
  - index {byte2,byte1} ≠ 0x2400, or subindex byte3 = 0, or byte3 > N_ADC: abort with code 0x06020000.
  - Otherwise go to ADC_REQ.
- ADC_REQ: adc_rd_en = 1 for exactly one cycle and adc_ch = byte3, held until SEND exits. Then go to ADC_WAIT.
- ADC_WAIT: on adc_valid, capture adc_value and build the normal response. If no adc_valid arrives within ADC_TIMEOUT cycles, abort with code 0x08000000.
- Normal response:
  - ID 0x580+NODE_ID.
  - byte0 0x43; bytes1–3 echo the request.
  - byte4 = adc_value[7:0], byte5 = adc_value[15:8]; bytes6–7 = 0.
- Abort response:
  - ID 0x580+NODE_ID.
  - byte0 0x80; bytes1–3 echo the request.
  - bytes4–7 hold the abort code, little-endian. abort_cnt increments and saturates at 0xFF.
- DELAY: count RESP_DELAY cycles, then go to SEND.
- SEND: rsp_valid = 1 and rsp_frame is held stable until rsp_ready is sampled high. Then go to IDLE.
- sign_on: a rising edge sets boot_pend in any state. boot_pend is cleared when the bootup frame is built. A second edge while the flag is already set merges into the single pending bootup.
- req_cnt wraps from 0xFFFF to 0x0000.
- Reset: state IDLE and all outputs 0, including rsp_frame, adc_ch, both counters and boot_pend. The sign_on edge detector is reset to 0. A reset during any state drops the transaction in progress without a response.

## Timing
- Handshake at edge E in IDLE: DECODE in cycle E+1. On a normal request, adc_rd_en is high in cycle E+2.
- adc_valid seen in cycle c: rsp_valid rises at cycle c+1+RESP_DELAY.
- Abort from DECODE: rsp_valid rises at cycle E+2+RESP_DELAY.
- Timeout: the abort is built in the cycle where the wait counter reaches ADC_TIMEOUT after ADC_REQ.
- adc_valid asserted outside ADC_WAIT is ignored.
- rsp_ready asserted on the first SEND cycle gives a one-cycle rsp_valid pulse; req_ready returns to 1 the next cycle.
- Back-to-back requests: the minimum inter-accept period is the response latency plus 1.

## Test plan
- NODE_ID 0, RESP_DELAY 0: request ID 0x600, data 40 00 24 05 00 00 00 00; adc_valid with 0x1A2B two cycles after adc_rd_en, where adc_ch = 5. Required: response ID 0x580, data 43 00 24 05 2B 1A 00 00; req_cnt = 1.
- Subindex 0x24 with N_ADC 35: response 80 00 24 24 00 00 02 06; abort_cnt = 1; adc_rd_en is never asserted.
- Command byte 0x23: abort with code bytes 01 00 04 05. Request ID 0x601: no rsp_valid, req_cnt unchanged.
- adc_valid withheld: after ADC_TIMEOUT = 255 cycles the response is an abort with code bytes 00 00 00 08.
- sign_on rising edge during ADC_WAIT: the current response completes first. Then the bootup frame ID 0x700 with data all zero is sent, and req_ready stays 0 until the bootup is taken.
- rsp_ready held low for 20 cycles: rsp_valid and rsp_frame are stable throughout. Reset during SEND: rsp_valid = 0 on the next edge, state IDLE, counters 0.
